// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter that shares one UART transmitter between two
// byte-stream requesters and aborts a byte if the UART never reports it started.
module uart_tx_arbiter #(
    parameter int unsigned START_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       uart_transmit,
    output logic [7:0] uart_tx_byte,
    input  logic       uart_is_transmitting,
    output logic       owner,
    output logic       locked,
    output logic       busy,
    output logic       tx_timeout
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_START,
        WAIT_DONE
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(START_TIMEOUT - 1);

    state_t     state_q;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic [7:0] tx_byte_q;
    logic       transmit_q;
    logic       ready0_q;
    logic       ready1_q;
    logic       owner_q;
    logic       locked_q;
    logic       timeout_q;

    logic       elig0;
    logic       elig1;
    logic       grant0;
    logic       grant1;

    // A stale UART busy flag blocks both requesters; a locked packet admits only its owner.
    assign elig0  = req0_valid && !uart_is_transmitting && (!locked_q || !owner_q);
    assign elig1  = req1_valid && !uart_is_transmitting && (!locked_q ||  owner_q);
    assign grant1 = elig1 && (!elig0 || !owner_q);
    assign grant0 = elig0 && !grant1;
    assign cnt_d  = cnt_q + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            tx_byte_q  <= 8'h00;
            transmit_q <= 1'b0;
            ready0_q   <= 1'b0;
            ready1_q   <= 1'b0;
            owner_q    <= 1'b1;
            locked_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            transmit_q <= 1'b0;
            ready0_q   <= 1'b0;
            ready1_q   <= 1'b0;
            timeout_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant0 || grant1) begin
                        tx_byte_q  <= grant1 ? req1_data : req0_data;
                        transmit_q <= 1'b1;
                        ready0_q   <= grant0;
                        ready1_q   <= grant1;
                        owner_q    <= grant1;
                        locked_q   <= grant1 ? ~req1_last : ~req0_last;
                        cnt_q      <= 8'd0;
                        state_q    <= WAIT_START;
                    end
                end
                WAIT_START: begin
                    cnt_q <= cnt_d;
                    if (uart_is_transmitting) begin
                        state_q <= WAIT_DONE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        // UART never started: abandon the byte and the rest of its packet.
                        state_q   <= IDLE;
                        timeout_q <= 1'b1;
                        locked_q  <= 1'b0;
                    end
                end
                WAIT_DONE: begin
                    if (!uart_is_transmitting) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req0_ready    = ready0_q;
    assign req1_ready    = ready1_q;
    assign uart_transmit = transmit_q;
    assign uart_tx_byte  = tx_byte_q;
    assign owner         = owner_q;
    assign locked        = locked_q;
    assign busy          = (state_q != IDLE);
    assign tx_timeout    = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a vector table of arbitration transactions plus
// hand-written sequences for owner stall, start timeout and reset during a frame.
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_last, req1_valid, req1_last;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic       uart_transmit;
    logic [7:0] uart_tx_byte;
    logic       uart_is_transmitting;
    logic       owner, locked, busy, tx_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // Simple UART model: busy rises at the edge that samples the start pulse, lasts 20 cycles.
    logic       model_en = 1'b1;
    logic [5:0] hold     = '0;
    assign uart_is_transmitting = (hold != 6'd0);

    always @(posedge clk) begin
        if (model_en && uart_transmit && hold == 6'd0) hold <= 6'd20;
        else if (hold != 6'd0)                          hold <= hold - 6'd1;
    end

    always #5 clk = ~clk;

    uart_tx_arbiter #(.START_TIMEOUT(16)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .req0_valid           (req0_valid),
        .req0_data            (req0_data),
        .req0_last            (req0_last),
        .req0_ready           (req0_ready),
        .req1_valid           (req1_valid),
        .req1_data            (req1_data),
        .req1_last            (req1_last),
        .req1_ready           (req1_ready),
        .uart_transmit        (uart_transmit),
        .uart_tx_byte         (uart_tx_byte),
        .uart_is_transmitting (uart_is_transmitting),
        .owner                (owner),
        .locked               (locked),
        .busy                 (busy),
        .tx_timeout           (tx_timeout)
    );

    typedef struct packed {
        logic       v0;
        logic [7:0] d0;
        logic       l0;
        logic       v1;
        logic [7:0] d1;
        logic       l1;
        logic [7:0] exp_byte;
        logic       exp_owner;
        logic       exp_locked;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic bound_fail(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    // Waits for the start pulse and checks the grant it represents.
    task automatic expect_grant(input string nm, input logic [7:0] b, input logic own, input logic lk);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!uart_transmit && n < 300);
        if (!uart_transmit) begin
            bound_fail({nm, " grant"});
        end else begin
            $display("%s: byte=%02h ready=%b%b owner=%0d locked=%0d",
                     nm, uart_tx_byte, req1_ready, req0_ready, owner, locked);
            check({nm, " byte"},   uart_tx_byte, b);
            check({nm, " ready"},  {req1_ready, req0_ready}, own ? 2'b10 : 2'b01);
            check({nm, " owner"},  owner, own);
            check({nm, " locked"}, locked, lk);
        end
    endtask

    // Waits for the UART frame to end; busy must be low one cycle after the UART flag drops.
    task automatic wait_done(input string nm);
        int n = 0;
        while (!uart_is_transmitting && n < 50) begin @(negedge clk); n++; end
        if (!uart_is_transmitting) bound_fail({nm, " uart start"});
        n = 0;
        while (uart_is_transmitting && n < 100) begin @(negedge clk); n++; end
        if (uart_is_transmitting) bound_fail({nm, " uart end"});
        @(negedge clk);
        check({nm, " busy after frame"}, busy, 1'b0);
    endtask

    always @(negedge clk) begin
        if (tx_timeout) begin
            n_checks++;
            if (uart_transmit) begin
                n_fail++;
                $display("FAIL timeout/transmit overlap: transmit=%b, expected 0", uart_transmit);
            end
        end
        if (req0_ready || req1_ready) begin
            n_checks++;
            if (!uart_transmit) begin
                n_fail++;
                $display("FAIL ready without pulse: transmit=%b, expected 1", uart_transmit);
            end
        end
    end

    initial begin
        int   t;
        int   cnt;
        vecs[0]  = '{1'b1, 8'h41, 1'b1, 1'b0, 8'h00, 1'b0, 8'h41, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'h10, 1'b1, 1'b1, 8'h20, 1'b1, 8'h20, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 8'h10, 1'b1, 1'b1, 8'h21, 1'b1, 8'h10, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 8'h11, 1'b1, 1'b1, 8'h21, 1'b1, 8'h21, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0, 8'h11, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 8'hA0, 1'b0, 1'b0, 8'h00, 1'b0, 8'hA0, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 8'hB0, 1'b1, 8'hA1, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 8'hA2, 1'b1, 1'b1, 8'hB0, 1'b1, 8'hA2, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 8'hC0, 1'b1, 1'b1, 8'hB0, 1'b1, 8'hB0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 8'hC0, 1'b1, 1'b1, 8'hD0, 1'b0, 8'hC0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hD0, 1'b0, 8'hD0, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 8'hE0, 1'b1, 1'b1, 8'hD1, 1'b1, 8'hD1, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 8'hE0, 1'b1, 1'b0, 8'h00, 1'b0, 8'hE0, 1'b0, 1'b0};

        rst = 1'b1;
        req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
        req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset transmit", uart_transmit, 1'b0);
        check("reset tx_byte",  uart_tx_byte, 8'h00);
        check("reset ready",    {req1_ready, req0_ready}, 2'b00);
        check("reset owner",    owner, 1'b1);
        check("reset locked",   locked, 1'b0);
        check("reset busy",     busy, 1'b0);
        check("reset timeout",  tx_timeout, 1'b0);

        for (int i = 0; i < 13; i++) begin
            req0_valid = vecs[i].v0; req0_data = vecs[i].d0; req0_last = vecs[i].l0;
            req1_valid = vecs[i].v1; req1_data = vecs[i].d1; req1_last = vecs[i].l1;
            expect_grant($sformatf("vec %0d", i), vecs[i].exp_byte, vecs[i].exp_owner, vecs[i].exp_locked);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            wait_done($sformatf("vec %0d", i));
        end

        // Locked owner goes quiet: the other requester must not slip in.
        req0_valid = 1'b1; req0_data = 8'hA0; req0_last = 1'b0;
        expect_grant("stall A0", 8'hA0, 1'b0, 1'b1);
        req0_valid = 1'b0;
        wait_done("stall A0");
        req1_valid = 1'b1; req1_data = 8'hB5; req1_last = 1'b1;
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (uart_transmit) cnt++;
        end
        check("stall no grant", cnt, 0);
        req0_valid = 1'b1; req0_data = 8'hA1; req0_last = 1'b1;
        expect_grant("stall A1", 8'hA1, 1'b0, 1'b0);
        req0_valid = 1'b0;
        wait_done("stall A1");
        expect_grant("stall B5", 8'hB5, 1'b1, 1'b0);
        req1_valid = 1'b0;
        wait_done("stall B5");

        // UART never starts the byte.
        model_en = 1'b0;
        req0_valid = 1'b1; req0_data = 8'h55; req0_last = 1'b0;
        expect_grant("timeout grant", 8'h55, 1'b0, 1'b1);
        req0_valid = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!tx_timeout && t < 40);
        $display("timeout: pulse after %0d cycles locked=%0d busy=%0d", t, locked, busy);
        check("timeout latency", t, 16);
        check("timeout locked",  locked, 1'b0);
        check("timeout busy",    busy, 1'b0);
        check("timeout owner",   owner, 1'b0);
        @(negedge clk);
        check("timeout pulse width", tx_timeout, 1'b0);
        model_en = 1'b1;
        req0_valid = 1'b1; req0_data = 8'h56; req0_last = 1'b1;
        expect_grant("after timeout", 8'h56, 1'b0, 1'b0);
        req0_valid = 1'b0;
        wait_done("after timeout");

        // Asynchronous reset while a locked packet is mid-frame.
        req0_valid = 1'b1; req0_data = 8'h60; req0_last = 1'b0;
        expect_grant("reset grant", 8'h60, 1'b0, 1'b1);
        req0_valid = 1'b0;
        t = 0;
        while (!uart_is_transmitting && t < 50) begin @(negedge clk); t++; end
        if (!uart_is_transmitting) bound_fail("reset uart start");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        $display("reset mid-frame: busy=%0d locked=%0d owner=%0d", busy, locked, owner);
        check("midreset busy",     busy, 1'b0);
        check("midreset locked",   locked, 1'b0);
        check("midreset owner",    owner, 1'b1);
        check("midreset transmit", uart_transmit, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b1; req0_data = 8'h61; req0_last = 1'b1;
        req1_valid = 1'b1; req1_data = 8'h71; req1_last = 1'b1;
        cnt = 0;
        t = 0;
        while (uart_is_transmitting && t < 100) begin
            @(negedge clk);
            t++;
            if (uart_transmit) cnt++;
        end
        if (uart_is_transmitting) bound_fail("midreset uart end");
        check("midreset no grant while busy", cnt, 0);
        expect_grant("post reset tie", 8'h61, 1'b0, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_done("post reset tie");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single transmit side of the `uart` core between two byte-stream requesters, such as the echo path and a status/message source. Arbitration is round-robin with packet locking: once a requester wins, it keeps the transmitter until it sends a byte flagged `last`. The block drives the UART's `transmit`/`tx_byte` inputs and sequences each byte off `is_transmitting`. It also aborts cleanly if the UART never starts a byte.

## Interface
- `START_TIMEOUT`, default 16: clock cycles allowed between the `uart_transmit` pulse and `uart_is_transmitting` rising; valid range 2..255.
- `clk`  in  1  system clock (12 MHz on the board).
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has a byte pending.
- `req0_data`  in  8  requester 0 byte.
- `req0_last`  in  1  byte is the final byte of requester 0's packet.
- `req0_ready`  out  1  one-cycle pulse: requester 0's byte was accepted at the previous edge.
- `req1_valid`, `req1_data`, `req1_last`, `req1_ready`: same as requester 0, for requester 1.
- `uart_transmit`  out  1  one-cycle start pulse to the UART.
- `uart_tx_byte`  out  8  byte to the UART; held stable from the pulse until the block returns to IDLE.
- `uart_is_transmitting`  in  1  UART busy flag.
- `owner`  out  1  requester currently or last granted.
- `locked`  out  1  packet in progress; only `owner` is eligible.
- `busy`  out  1  state ≠ IDLE.
- `tx_timeout`  out  1  one-cycle pulse on start-timeout abort.

## Operation
- States: IDLE, WAIT_START, WAIT_DONE. Encoding is free.
- Reset values: state IDLE; all outputs 0; `uart_tx_byte` = 8'h00; timeout counter 0. Round-robin pointer `owner` = 1, so requester 0 wins the first tie.
- Eligibility in IDLE:
  - A requester is eligible when its `valid` = 1 and `uart_is_transmitting` = 0.
  - If `locked`, only `owner` is eligible. The block waits indefinitely in IDLE for the owner; the other requester is ignored.
- Grant in IDLE:
  - One requester eligible: grant it.
  - Both eligible and unlocked: grant the requester ≠ `owner`.
- On a grant to requester k at an edge:
  - `uart_tx_byte` <= `reqk_data`.
  - `uart_transmit` <= 1 and `reqk_ready` <= 1, each for exactly one cycle.
  - `owner` <= k.
  - `locked` <= ~`reqk_last`.
  - Counter <= 0; state <= WAIT_START.
- WAIT_START:
  - Counter increments each cycle.
  - `uart_is_transmitting` = 1: go to WAIT_DONE.
  - Otherwise, counter reaches `START_TIMEOUT`−1: go to IDLE, pulse `tx_timeout`, clear `locked` (packet aborted). `owner` is unchanged.
- WAIT_DONE: `uart_is_transmitting` = 0 → IDLE.
- Requester contract:
  - Hold `valid`/`data`/`last` stable until `ready` is seen.
  - Data may change on the edge where `ready` = 1 is sampled.
  - The block never resamples a requester before returning to IDLE.
- `uart_is_transmitting` high while in IDLE (a stale busy flag): no grant until it drops.
- Counter width: 8 bits; saturation is not required, because the counter is cleared on every grant.

## Timing
- Grant edge E: `uart_transmit` and `ready` are high during cycle E+1 only.
- Minimum per-byte occupancy: 1 cycle WAIT_START + UART frame time + 1 cycle back to IDLE. Earliest next grant is the edge after the return to IDLE.
- Back-to-back bytes of a locked packet add no arbitration bubble beyond that one IDLE cycle.
- Reset mid-operation (any state): immediate return to the reset values.
  - `uart_transmit` drops even if it was mid-pulse.
  - `locked` is cleared; a packet in progress is abandoned.
  - A UART frame already started finishes on its own. After reset, the block waits in IDLE until `uart_is_transmitting` = 0.
- `tx_timeout` and `uart_transmit` are never high in the same cycle.

## Test plan
- Single byte: `req0_valid`=1, data 8'h41, `last`=1; UART model raises busy 1 cycle after the pulse and holds it 20 cycles. Required: one pulse with `uart_tx_byte`=8'h41, `req0_ready` pulse on the same cycle, `locked`=0, `busy` low 1 cycle after busy falls.
- Tie, round-robin: both requesters valid continuously with single-byte packets (`last`=1), req0 bytes 8'h10, 8'h11, req1 bytes 8'h20, 8'h21. Required UART order: 10, 20, 11, 21.
- Packet lock: req0 sends 3 bytes A0, A1, A2 (`last` only on A2) while req1 holds 8'hB0 valid throughout. Required order: A0, A1, A2, B0; `locked`=1 from the A0 grant until the A2 grant.
- Locked owner stalls: after req0 sends A0 (`last`=0), req0 drops valid for 50 cycles while req1 stays valid. Required: no grant to req1 during the stall; the req0 byte sent after the stall goes first.
- Start timeout with `START_TIMEOUT`=16: UART model never raises busy. Required: `tx_timeout` pulse 16 cycles after the grant edge, return to IDLE, `locked` cleared, next request accepted normally.
- Async reset asserted mid-WAIT_DONE with `locked`=1: required immediate `busy`=0, `locked`=0, `owner`=1; no grant while busy is still high; first grant after busy falls goes to req0 on a tie.
